// File: rtl/instr_sequencer.sv
// Multi-cycle instruction sequencer for the Nandy CPU. It latches the current
// instruction, counts its cycles, stretches memory cycles and raises sticky signal flags.
module instr_sequencer #(
  parameter int INST_W     = 8,
  parameter int EXT_CYCLES = 1,
  parameter int NUM_SIG    = 8,
  localparam int CYC_W     = (EXT_CYCLES < 2) ? 1 : $clog2(EXT_CYCLES + 1)
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic [INST_W-1:0]  inst_i,
  input  logic               inst_valid_i,
  output logic               inst_ready_o,
  input  logic               mem_ready_i,
  input  logic               carry_i,
  input  logic [NUM_SIG-1:0] sig_ack_i,
  output logic [INST_W-1:0]  ir_o,
  output logic [CYC_W-1:0]   cycle_o,
  output logic               busy_o,
  output logic               stall_o,
  output logic               instr_done_o,
  output logic               jump_taken_o,
  output logic [NUM_SIG-1:0] sig_pending_o
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXEC,
    S_WAIT
  } state_e;

  state_e             state_q, state_d;
  logic [INST_W-1:0]  ir_q, ir_d;
  logic [CYC_W-1:0]   cycle_q, cycle_d;
  logic [NUM_SIG-1:0] sig_q, sig_d;

  logic               isLong, isMem, isJump, isSig;
  logic               lastCycle, memWait, retire;
  logic [NUM_SIG-1:0] setMask;

  assign isLong    = ir_q[7];
  assign isMem     = (ir_q[7:6] == 2'b10);
  assign isJump    = (ir_q[7:5] == 3'b111);
  assign isSig     = (ir_q[7:3] == 5'b00011);
  assign lastCycle = isLong ? (cycle_q == CYC_W'(EXT_CYCLES)) : (cycle_q == '0);
  // Only meaningful while busy; in WAIT this is simply !mem_ready_i.
  assign memWait   = isMem && (cycle_q != '0) && !mem_ready_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      ir_q    <= '0;
      cycle_q <= '0;
      sig_q   <= '0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      cycle_q <= cycle_d;
      sig_q   <= sig_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    cycle_d = cycle_q;
    case (state_q)
      S_IDLE: begin
        if (inst_valid_i) begin
          ir_d    = inst_i;
          cycle_d = '0;
          state_d = S_EXEC;
        end
      end
      S_EXEC, S_WAIT: begin
        if (memWait) begin
          state_d = S_WAIT;
        end else if (lastCycle) begin
          if (inst_valid_i) begin
            ir_d    = inst_i;
            cycle_d = '0;
            state_d = S_EXEC;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          cycle_d = cycle_q + CYC_W'(1);
          state_d = S_EXEC;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // A set in the retire cycle overrides a simultaneous acknowledge.
    sig_d = (sig_q & ~sig_ack_i) | setMask;
  end

  always_comb begin
    busy_o       = (state_q != S_IDLE);
    stall_o      = (state_q == S_WAIT);
    retire       = busy_o && !memWait && lastCycle;
    instr_done_o = retire;
    inst_ready_o = (state_q == S_IDLE) || retire;
    jump_taken_o = retire && isJump && !(ir_q[4] && carry_i);
    setMask      = '0;
    for (int i = 0; i < NUM_SIG; i++) begin
      if (retire && isSig && (ir_q[2:0] == 3'(i))) begin
        setMask[i] = 1'b1;
      end
    end
  end

  assign ir_o          = ir_q;
  assign cycle_o       = cycle_q;
  assign sig_pending_o = sig_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed bench for instr_sequencer: dutA uses EXT_CYCLES=2/NUM_SIG=8,
// dutB uses EXT_CYCLES=1/NUM_SIG=4 for the memory-wait and narrow-signal cases.
module tb_instr_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic       aRstN, aValid, aMemReady, aCarry;
  logic [7:0] aInst, aAck, aIr, aSig;
  logic [1:0] aCycle;
  logic       aReady, aBusy, aStall, aDone, aJump;

  logic       bRstN, bValid, bMemReady, bCarry;
  logic [7:0] bInst, bIr;
  logic [3:0] bAck, bSig;
  logic [0:0] bCycle;
  logic       bReady, bBusy, bStall, bDone, bJump;

  instr_sequencer #(.INST_W(8), .EXT_CYCLES(2), .NUM_SIG(8)) dutA (
    .clk_i(clk), .rst_ni(aRstN), .inst_i(aInst), .inst_valid_i(aValid),
    .inst_ready_o(aReady), .mem_ready_i(aMemReady), .carry_i(aCarry),
    .sig_ack_i(aAck), .ir_o(aIr), .cycle_o(aCycle), .busy_o(aBusy),
    .stall_o(aStall), .instr_done_o(aDone), .jump_taken_o(aJump),
    .sig_pending_o(aSig)
  );

  instr_sequencer #(.INST_W(8), .EXT_CYCLES(1), .NUM_SIG(4)) dutB (
    .clk_i(clk), .rst_ni(bRstN), .inst_i(bInst), .inst_valid_i(bValid),
    .inst_ready_o(bReady), .mem_ready_i(bMemReady), .carry_i(bCarry),
    .sig_ack_i(bAck), .ir_o(bIr), .cycle_o(bCycle), .busy_o(bBusy),
    .stall_o(bStall), .instr_done_o(bDone), .jump_taken_o(bJump),
    .sig_pending_o(bSig)
  );

  // Reset values, then an asynchronous reset in the middle of a long instruction.
  task automatic test_reset();
    logic doneSeen;
    #1;
    total++; if (aReady !== 1'b1) begin bad++; $display("[TB] FAIL reset_ready got=%b want=1", aReady); end
    total++; if (aBusy !== 1'b0) begin bad++; $display("[TB] FAIL reset_busy got=%b want=0", aBusy); end
    total++; if (aIr !== 8'h00) begin bad++; $display("[TB] FAIL reset_ir got=%h want=00", aIr); end
    total++; if (aSig !== 8'h00) begin bad++; $display("[TB] FAIL reset_sig got=%h want=00", aSig); end
    @(negedge clk); aRstN = 1'b1;
    @(negedge clk); aInst = 8'hC0; aValid = 1'b1;
    @(negedge clk); aValid = 1'b0; #1;
    total++; if (aBusy !== 1'b1) begin bad++; $display("[TB] FAIL midrst_busy got=%b want=1", aBusy); end
    total++; if (aCycle !== 2'd0) begin bad++; $display("[TB] FAIL midrst_cyc0 got=%0d want=0", aCycle); end
    @(negedge clk); #1;
    total++; if (aCycle !== 2'd1) begin bad++; $display("[TB] FAIL midrst_cyc1 got=%0d want=1", aCycle); end
    aRstN = 1'b0; #1;
    total++; if (aBusy !== 1'b0) begin bad++; $display("[TB] FAIL async_busy got=%b want=0", aBusy); end
    total++; if (aCycle !== 2'd0) begin bad++; $display("[TB] FAIL async_cycle got=%0d want=0", aCycle); end
    total++; if (aIr !== 8'h00) begin bad++; $display("[TB] FAIL async_ir got=%h want=00", aIr); end
    total++; if (aReady !== 1'b1) begin bad++; $display("[TB] FAIL async_ready got=%b want=1", aReady); end
    total++; if (aDone !== 1'b0 || aStall !== 1'b0 || aJump !== 1'b0) begin
      bad++; $display("[TB] FAIL async_pulses got=%b%b%b want=000", aDone, aStall, aJump);
    end
    @(negedge clk); aRstN = 1'b1;
    doneSeen = 1'b0;
    repeat (5) begin
      @(negedge clk); #1;
      if (aDone === 1'b1) doneSeen = 1'b1;
    end
    total++; if (doneSeen !== 1'b0) begin bad++; $display("[TB] FAIL post_rst_done got=%b want=0", doneSeen); end
    total++; if (aReady !== 1'b1) begin bad++; $display("[TB] FAIL post_rst_ready got=%b want=1", aReady); end
  endtask

  // Three short instructions with inst_valid held high retire on consecutive clocks.
  task automatic test_back_to_back();
    logic [7:0] seq [3];
    seq[0] = 8'h04; seq[1] = 8'h08; seq[2] = 8'h45;
    @(negedge clk); aInst = seq[0]; aValid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      total++; if (aIr !== seq[i]) begin bad++; $display("[TB] FAIL b2b_ir%0d got=%h want=%h", i, aIr, seq[i]); end
      total++; if (aCycle !== 2'd0) begin bad++; $display("[TB] FAIL b2b_cycle%0d got=%0d want=0", i, aCycle); end
      total++; if (aDone !== 1'b1) begin bad++; $display("[TB] FAIL b2b_done%0d got=%b want=1", i, aDone); end
      if (i < 2) aInst = seq[i+1];
      else aValid = 1'b0;
    end
    @(negedge clk); #1;
    total++; if (aDone !== 1'b0) begin bad++; $display("[TB] FAIL b2b_idle_done got=%b want=0", aDone); end
    total++; if (aBusy !== 1'b0) begin bad++; $display("[TB] FAIL b2b_idle_busy got=%b want=0", aBusy); end
  endtask

  // Memory instruction 0x80 with mem_ready low for three clocks during cycle 1.
  task automatic test_mem_wait();
    int stallCnt;
    stallCnt = 0;
    @(negedge clk); bInst = 8'h80; bValid = 1'b1; bMemReady = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      bValid = 1'b0;
      bMemReady = (k >= 5);
      #1;
      total++; if (bDone !== (k == 5)) begin bad++; $display("[TB] FAIL mem_done_k%0d got=%b want=%b", k, bDone, (k == 5)); end
      if (k >= 2 && k <= 5) begin
        total++; if (bCycle !== 1'b1) begin bad++; $display("[TB] FAIL mem_cycle_k%0d got=%0d want=1", k, bCycle); end
        total++; if (bBusy !== 1'b1) begin bad++; $display("[TB] FAIL mem_busy_k%0d got=%b want=1", k, bBusy); end
      end
      if (bStall === 1'b1) stallCnt++;
    end
    total++; if (stallCnt != 3) begin bad++; $display("[TB] FAIL mem_stall_cycles got=%0d want=3", stallCnt); end
    total++; if (bReady !== 1'b1) begin bad++; $display("[TB] FAIL mem_idle_ready got=%b want=1", bReady); end
  endtask

  // Jump taken/not-taken decided by ir[4] and carry in the retire cycle.
  task automatic test_jumps();
    logic [7:0] vInst [3];
    logic       vCarry [3];
    logic       vJump [3];
    logic       seen, jumpAtRetire;
    int         retireIdx;
    vInst[0] = 8'hF0; vCarry[0] = 1'b1; vJump[0] = 1'b0;
    vInst[1] = 8'hF0; vCarry[1] = 1'b0; vJump[1] = 1'b1;
    vInst[2] = 8'hE0; vCarry[2] = 1'b1; vJump[2] = 1'b1;
    for (int v = 0; v < 3; v++) begin
      @(negedge clk); aInst = vInst[v]; aCarry = vCarry[v]; aValid = 1'b1;
      seen = 1'b0; jumpAtRetire = 1'b0; retireIdx = -1;
      for (int k = 0; k < 10 && !seen; k++) begin
        @(negedge clk); aValid = 1'b0; #1;
        if (aDone === 1'b1) begin
          seen = 1'b1; jumpAtRetire = aJump; retireIdx = k;
        end
      end
      total++; if (seen !== 1'b1) begin bad++; $display("[TB] FAIL jump%0d_timeout got=%b want=1", v, seen); end
      total++; if (retireIdx != 2) begin bad++; $display("[TB] FAIL jump%0d_latency got=%0d want=2", v, retireIdx); end
      total++; if (jumpAtRetire !== vJump[v]) begin bad++; $display("[TB] FAIL jump%0d_taken got=%b want=%b", v, jumpAtRetire, vJump[v]); end
    end
    aCarry = 1'b0;
  endtask

  // Sticky flag on channel 5, set-over-ack priority, then a plain ack.
  task automatic test_signals();
    @(negedge clk); aInst = 8'h1D; aValid = 1'b1;
    @(negedge clk); aValid = 1'b0; #1;
    total++; if (aDone !== 1'b1) begin bad++; $display("[TB] FAIL sig_done1 got=%b want=1", aDone); end
    @(negedge clk); #1;
    total++; if (aSig !== 8'h20) begin bad++; $display("[TB] FAIL sig_set got=%h want=20", aSig); end
    aInst = 8'h1D; aValid = 1'b1;
    @(negedge clk); aValid = 1'b0; aAck = 8'h20; #1;
    total++; if (aDone !== 1'b1) begin bad++; $display("[TB] FAIL sig_done2 got=%b want=1", aDone); end
    @(negedge clk); aAck = 8'h00; #1;
    total++; if (aSig !== 8'h20) begin bad++; $display("[TB] FAIL sig_set_wins got=%h want=20", aSig); end
    aAck = 8'h20;
    @(negedge clk); aAck = 8'h00; #1;
    total++; if (aSig !== 8'h00) begin bad++; $display("[TB] FAIL sig_ack_clear got=%h want=00", aSig); end
  endtask

  // With four channels, channel 6 is ignored while channel 1 stays set.
  task automatic test_narrow();
    @(negedge clk); bInst = 8'h19; bValid = 1'b1;
    @(negedge clk); bValid = 1'b0;
    @(negedge clk); #1;
    total++; if (bSig !== 4'h2) begin bad++; $display("[TB] FAIL narrow_ch1 got=%h want=2", bSig); end
    bInst = 8'h1E; bValid = 1'b1;
    @(negedge clk); bValid = 1'b0; #1;
    total++; if (bDone !== 1'b1) begin bad++; $display("[TB] FAIL narrow_done got=%b want=1", bDone); end
    total++; if (bIr !== 8'h1E) begin bad++; $display("[TB] FAIL narrow_ir got=%h want=1e", bIr); end
    total++; if (bJump !== 1'b0) begin bad++; $display("[TB] FAIL narrow_jump got=%b want=0", bJump); end
    @(negedge clk); #1;
    total++; if (bSig !== 4'h2) begin bad++; $display("[TB] FAIL narrow_unchanged got=%h want=2", bSig); end
    total++; if (bDone !== 1'b0) begin bad++; $display("[TB] FAIL narrow_done_end got=%b want=0", bDone); end
  endtask

  initial begin
    aRstN = 1'b0; aValid = 1'b0; aMemReady = 1'b0; aCarry = 1'b0; aInst = 8'h00; aAck = 8'h00;
    bRstN = 1'b0; bValid = 1'b0; bMemReady = 1'b0; bCarry = 1'b0; bInst = 8'h00; bAck = 4'h0;
    test_reset();
    @(negedge clk); bRstN = 1'b1;
    test_back_to_back();
    test_mem_wait();
    test_jumps();
    test_signals();
    test_narrow();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/instr_sequencer.md
# instr_sequencer

Registered, parametrised instruction sequencer for the Nandy CPU. It replaces the single externally-driven `cycle`/`ncycle` bit used by the combinational control decoder with a programmable multi-cycle counter. It adds an instruction-accept handshake, memory wait-state stretching, and sticky per-channel signal flags with acknowledge. It sits between the fetch stage and the combinational control decoder, which consumes `ir` and `cycle`.

## Interface
- `INST_W`, 8: instruction width; must be at least 8.
- `EXT_CYCLES`, 1: extra cycles beyond cycle 0 for instructions with `inst[7]=1`; range 1..7.
- `NUM_SIG`, 8: number of signal channels; range 1..8.
- `CYC_W`, derived, `max(1, clog2(EXT_CYCLES+1))`: width of `cycle`.

Ports:
- `clk`, input, 1: single clock, rising-edge.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `inst`, input, INST_W: instruction from fetch.
- `inst_valid`, input, 1: `inst` is valid.
- `inst_ready`, output, 1: the sequencer accepts `inst` on this edge.
- `mem_ready`, input, 1: memory completes its access this cycle.
- `carry`, input, 1: carry flag.
- `sig_ack`, input, NUM_SIG: per-channel clear of the pending signal flag.
- `ir`, output, INST_W: latched current instruction.
- `cycle`, output, CYC_W: cycle index within the current instruction.
- `busy`, output, 1: an instruction is in flight.
- `stall`, output, 1: a memory wait state is active.
- `instr_done`, output, 1: one-cycle pulse when an instruction retires.
- `jump_taken`, output, 1: one-cycle pulse in the retire cycle of a taken jump.
- `sig_pending`, output, NUM_SIG: sticky signal flags.

## Operation
Instruction classes (decoded from `ir`):
- Long instruction: `ir[7]=1`. Needs `EXT_CYCLES+1` cycles. All other instructions need 1 cycle.
- Memory instruction: `ir[7:6]=10`. Cycles 1 and above wait for `mem_ready`.
- Jump: `ir[7:5]=111`. Taken unless `ir[4]&carry`.
- Signal: `ir[7:3]=00011`. Targets channel `ir[2:0]`. Channels at or above NUM_SIG are ignored.

State machine:
- **IDLE:** `busy=0`, `inst_ready=1`. On `inst_valid`, load `ir`, clear `cycle`, and go to EXEC.
- **EXEC:** `busy=1`. Last cycle means `cycle==0` for a short instruction, or `cycle==EXT_CYCLES` for a long one.
  - In a memory instruction with `cycle>=1` and `mem_ready=0`: go to WAIT and hold `cycle`.
  - In the last cycle with no stall: retire.
  - Otherwise: increment `cycle`.
- **WAIT:** `busy=1`, `stall=1`, `cycle` held. On `mem_ready=1`, resume as EXEC at the same cycle value. This is the memory cycle, so it retires or advances on that edge.
- **Retire:**
  - Pulse `instr_done`. For a jump, pulse `jump_taken`, evaluated on `carry` in the retire cycle. For a signal instruction, set `sig_pending[ir[2:0]]`.
  - `inst_ready=1` in the retire cycle. If `inst_valid`, the next instruction loads back-to-back with no bubble; otherwise go to IDLE.
- **Signal flags:**
  - `sig_ack[i]` clears bit i on the next edge.
  - If set and ack land on the same bit in the same cycle, set wins.
  - Acking a bit that is already clear has no effect.

Reset (`rst_n=0`, asynchronous):
- State returns to IDLE; `ir=0`, `cycle=0`, `sig_pending=0`.
- `busy=0`, `stall=0`, `instr_done=0`, `jump_taken=0`, `inst_ready=1`.
- An in-flight instruction is abandoned with no retire pulse and no flag update.

## Timing
- `inst_ready`, `instr_done`, `jump_taken` and `stall` are combinational from the state registers and inputs (`mem_ready`, `carry`). Everything else is registered.
- Latency from acceptance to retire, counted in clocks including the acceptance edge:
  - short instruction: 1;
  - long instruction with no waits: `EXT_CYCLES+1`;
  - memory instruction: `EXT_CYCLES+1` plus one per cycle in which `mem_ready=0` during a memory cycle.
- Sustained throughput for short instructions is one per clock.
- `mem_ready` is ignored in cycle 0 and for non-memory instructions.
- `cycle` never exceeds `EXT_CYCLES`; it returns to 0 on reload and does not wrap.
- `inst_valid` while `inst_ready=0` is ignored; fetch must hold `inst`.

## Test plan
- **Reset:** assert `rst_n=0` mid-way through a long instruction at `cycle=1` with `EXT_CYCLES=2` → all outputs at reset values immediately, before the next edge. Release → `inst_ready=1`, and no `instr_done` pulse occurs.
- **Back-to-back short:** stream 0x04, 0x08, 0x45 with `inst_valid` held high → `instr_done` high on 3 consecutive clocks, `cycle` stays 0, `ir` follows each instruction.
- **Memory wait:** issue 0x80 with `EXT_CYCLES=1`, `mem_ready` low for 3 clocks → `stall` high for 3 clocks, `cycle=1` throughout, `instr_done` exactly 5 clocks after acceptance.
- **Jumps:** 0xF0 with `carry=1` → retire with `jump_taken=0`. 0xF0 with `carry=0` → `jump_taken=1`. 0xE0 with `carry=1` → `jump_taken=1`.
- **Signals:** 0x1D → `sig_pending=0x20`. Then 0x1D again with `sig_ack=0x20` in its retire cycle → bit stays set. Then `sig_ack=0x20` alone → `sig_pending=0`.
- **Narrow signals:** `NUM_SIG=4`, issue 0x1E → `sig_pending` unchanged and `instr_done` pulses normally.
